// File: rtl/mux21_arbiter_bmsce.sv
// Round-robin arbiter sharing a registered 2:1 mux data channel between two requesters.
// One-cycle grant latency, burst-limited tenure, no backpressure beyond the request/grant handshake.
module mux21_arbiter_bmsce #(
  parameter int MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  // Encoding chosen so the state bits are the grant outputs directly.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

  state_t     state;
  logic       sel;
  logic       y;
  logic [3:0] burst_cnt;

  logic req0, req1, data0, data1, arb_en;

  assign req0   = ui_in[0];
  assign req1   = ui_in[1];
  assign data0  = ui_in[2];
  assign data1  = ui_in[3];
  assign arb_en = uio_in[0];

  wire unused_ok = &{1'b0, ena, ui_in[7:4], uio_in[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= 1'b1;
      y         <= 1'b0;
      burst_cnt <= 4'd0;
    end else begin
      y <= (state == GNT0) ? data0 : (state == GNT1) ? data1 : 1'b0;
      if (!arb_en) begin
        state     <= IDLE;
        burst_cnt <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            burst_cnt <= 4'd0;
            // On a tie the side that did not own the channel last wins.
            if (req0 && (!req1 || sel)) begin
              state <= GNT0;
              sel   <= 1'b0;
            end else if (req1) begin
              state <= GNT1;
              sel   <= 1'b1;
            end
          end
          GNT0: begin
            if (req0) begin
              if (burst_cnt != LAST) begin
                burst_cnt <= burst_cnt + 4'd1;
              end else if (req1) begin
                state     <= GNT1;
                sel       <= 1'b1;
                burst_cnt <= 4'd0;
              end
            end else if (req1) begin
              state     <= GNT1;
              sel       <= 1'b1;
              burst_cnt <= 4'd0;
            end else begin
              state     <= IDLE;
              burst_cnt <= 4'd0;
            end
          end
          GNT1: begin
            if (req1) begin
              if (burst_cnt != LAST) begin
                burst_cnt <= burst_cnt + 4'd1;
              end else if (req0) begin
                state     <= GNT0;
                sel       <= 1'b0;
                burst_cnt <= 4'd0;
              end
            end else if (req0) begin
              state     <= GNT0;
              sel       <= 1'b0;
              burst_cnt <= 4'd0;
            end else begin
              state     <= IDLE;
              burst_cnt <= 4'd0;
            end
          end
          default: begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

  assign uo_out  = {burst_cnt, sel, state, y};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_mux21_arbiter_bmsce.sv
// Directed bench for mux21_arbiter_bmsce: hand-computed uo_out bytes checked after each edge.
module tb_mux21_arbiter_bmsce;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  int vectors;
  int miscompares;

  mux21_arbiter_bmsce #(.MAX_BURST(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // uo_out byte = {burst_cnt, sel, gnt1, gnt0, y}
  function automatic logic [7:0] uo(input logic [3:0] cnt, input logic s,
                                    input logic g1, input logic g0, input logic yy);
    return {cnt, s, g1, g0, yy};
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    ui_in  = 8'h00;
    uio_in = 8'h01;
    ena    = 1'b1;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_async", uo_out, 8'h08);
    check("reset_uio_oe", uio_oe, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    tick();
    tick();
    check("reset_held", uo_out, 8'h08);
    rst_n = 1'b1;

    // Tie from reset: req0 wins because sel starts at 1
    ui_in = 8'h03;
    check("tie_sel_before", uo_out, 8'h08);
    tick();
    check("tie_gnt0_cnt0", uo_out, uo(4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("gnt0_cnt%0d", k), uo_out, uo(4'(k), 1'b0, 1'b0, 1'b1, 1'b0));
    end
    tick();
    check("forced_switch_gnt1", uo_out, uo(4'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    check("gnt1_cnt1", uo_out, uo(4'd1, 1'b1, 1'b1, 1'b0, 1'b0));

    // Back to idle, then req1 alone with data1 toggling
    ui_in = 8'h00;
    tick();
    check("drop_to_idle", uo_out, 8'h08);
    ui_in = 8'h0A;
    tick();
    check("req1_grant", uo_out, uo(4'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    ui_in = 8'h0A;
    tick();
    check("data1_y1", uo_out, uo(4'd1, 1'b1, 1'b1, 1'b0, 1'b1));
    ui_in = 8'h02;
    tick();
    check("data1_y0", uo_out, uo(4'd2, 1'b1, 1'b1, 1'b0, 1'b0));
    ui_in = 8'h0A;
    tick();
    check("data1_y1b", uo_out, uo(4'd3, 1'b1, 1'b1, 1'b0, 1'b1));
    ui_in = 8'h00;
    tick();
    check("req1_drop_idle", uo_out, 8'h08);

    // req0 alone for 20 cycles with data0=1: saturation, no switch
    ui_in = 8'h05;
    tick();
    check("req0_grant", uo_out, uo(4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int i = 1; i <= 19; i++) begin
      tick();
      check($sformatf("req0_hold%0d", i), uo_out,
            uo((i > 7) ? 4'd7 : 4'(i), 1'b0, 1'b0, 1'b1, 1'b1));
    end
    ui_in = 8'h00;
    tick();
    check("req0_drop_idle", uo_out, 8'h00);
    tick();
    check("idle_y0", uo_out, 8'h00);

    // Tie with sel=0 grants req1
    ui_in = 8'h03;
    tick();
    check("tie_sel0_gnt1", uo_out, uo(4'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    // req1 drops with req0 waiting: direct handover
    ui_in = 8'h01;
    tick();
    check("handover_gnt0", uo_out, uo(4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    ui_in = 8'h03;
    tick();
    check("both_cnt1", uo_out, uo(4'd1, 1'b0, 1'b0, 1'b1, 1'b0));
    tick();
    check("both_cnt2", uo_out, uo(4'd2, 1'b0, 1'b0, 1'b1, 1'b0));
    tick();
    check("both_cnt3", uo_out, uo(4'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    ui_in = 8'h02;
    tick();
    check("drop_at3_gnt1", uo_out, uo(4'd0, 1'b1, 1'b1, 1'b0, 1'b0));

    // arb_en low forces idle and blocks grants
    ui_in = 8'h03;
    tick();
    check("gnt1_cnt1_b", uo_out, uo(4'd1, 1'b1, 1'b1, 1'b0, 1'b0));
    uio_in = 8'h00;
    tick();
    check("disable_idle", uo_out, 8'h08);
    tick();
    check("disabled_hold1", uo_out, 8'h08);
    tick();
    check("disabled_hold2", uo_out, 8'h08);
    uio_in = 8'h01;
    tick();
    check("reenable_gnt0", uo_out, uo(4'd0, 1'b0, 1'b0, 1'b1, 1'b0));

    // Asynchronous reset between edges while granted
    ui_in = 8'h07;
    tick();
    check("pre_reset_grant", uo_out, uo(4'd1, 1'b0, 1'b0, 1'b1, 1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("midgrant_reset", uo_out, 8'h08);
    check("end_uio_oe", uio_oe, 8'h00);
    check("end_uio_out", uio_out, 8'h00);
    tick();
    check("reset_hold_end", uo_out, 8'h08);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux21_arbiter_bmsce.md
Name: mux21_arbiter_bmsce

Overview:
Round-robin arbiter that shares the single-bit 2:1 mux output channel between two requesters.
- Sequences the mux select from request/grant state instead of a static pin.
- Bounds each owner's tenure with a burst limit.
- Drives the registered muxed data out.
- Top-level tile with the standard 8-bit ui/uo/uio pin set.

Parameters:
MAX_BURST, 8, maximum consecutive granted cycles per owner while the other side waits; legal range 2..16.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  reset; asynchronous, active-low
ui_in  input  8  [0]=req0, [1]=req1, [2]=data0, [3]=data1, [7:4] unused
uo_out  output  8  [0]=y (registered muxed data), [1]=gnt0, [2]=gnt1, [3]=sel (last/current owner), [7:4]=burst_cnt
uio_in  input  8  [0]=arb_en (1 = arbitration enabled), [7:1] unused
uio_out  output  8  tied 0
uio_oe  output  8  tied 0 (all uio pins are inputs)
ena  input  1  ignored

Behaviour:
Reset (rst_n=0, asynchronous):
- State=IDLE, gnt0=gnt1=0, y=0, burst_cnt=0.
- sel=1, so req0 wins the first tie.

States: IDLE, GNT0, GNT1. All outputs are registered.
- gnt0 = (state==GNT0); gnt1 = (state==GNT1).
- sel updates to the owner on every grant entry and holds its value in IDLE.

IDLE:
- req0&req1 -> grant the side != sel.
- Only one request -> grant that side.
- No request, or arb_en=0 -> stay in IDLE.
- Grant is visible one cycle after the request is sampled.

GNTn, owner request still high:
- burst_cnt < MAX_BURST-1: stay; burst_cnt+1.
- burst_cnt == MAX_BURST-1 and other side requesting: forced switch to the other GNT next cycle; burst_cnt -> 0.
- burst_cnt == MAX_BURST-1 and other side idle: stay; burst_cnt saturates at MAX_BURST-1.

GNTn, owner request dropped:
- Other side requesting -> go directly to the other GNT; no idle bubble; burst_cnt -> 0.
- Otherwise -> IDLE; burst_cnt -> 0.

Counter and gnt signals:
- burst_cnt is 0 on the first granted cycle.
- burst_cnt is 4 bits; uo_out[7:4] shows it directly.
- gnt0 and gnt1 are never both 1.

Data path:
- Each cycle: y <= (state==GNT0) ? data0 : (state==GNT1) ? data1 : 0.
- So y carries the owner's data bit presented during a granted cycle, one cycle later.

arb_en=0:
- From any state -> IDLE next cycle; burst_cnt -> 0; no new grants while low; sel retained.
- Re-enabling resumes the normal IDLE rules.

Simultaneous events:
- Request drop and burst expiry in the same cycle: the drop rule applies.
- arb_en=0 has priority over all transitions.

Reset mid-grant:
- All outputs clear immediately, asynchronously.
- Fairness pointer returns to sel=1.

Test Plan:
- Reset, then req0=req1=1 together -> gnt0=1 in the cycle after the sample; sel=1 before grant, 0 after; burst_cnt counts 0..7; forced switch to gnt1 after 8 granted cycles; gnt1 burst_cnt restarts at 0.
- req1 only, data1 toggles 1,0,1 while granted -> gnt1 held; y = 1,0,1 each one cycle later; gnt0 stays 0.
- req0 alone held 20 cycles -> gnt0 continuous; burst_cnt saturates at 7, no switch; drop req0 -> IDLE next cycle, y=0.
- Both requesting, in GNT0 at burst_cnt=3, req0 drops -> GNT1 the very next cycle (no IDLE), burst_cnt=0.
- In GNT1, arb_en=0 -> IDLE next cycle, gnt0=gnt1=0; requests ignored while low; arb_en=1 with both requesting -> gnt0 granted (sel was 1).
- Assert rst_n=0 mid-grant between clock edges -> gnt, y and burst_cnt go to 0 without a clock edge; uio_oe and uio_out stay 0x00 throughout all tests.
